// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: FSM states, ALU opcodes and instruction layout.
// Instruction word is {op, rd, rs1, rs2} with op in the MSBs.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int OP_W = 2;

    function automatic int instr_w(input int addr_w);
        return OP_W + 3 * addr_w;
    endfunction

    function automatic int op_lsb(input int addr_w);
        return 3 * addr_w;
    endfunction

    function automatic int rd_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int rs1_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int rs2_lsb(input int addr_w);
        return 0;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for alu_seq: two captured read ports, one muxed write
// port (write-back over external), one combinational debug read port.
module alu_seq_regfile #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    input  logic              ext_en,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // A write-back landing on the accept edge is forwarded so a dependent
    // instruction issued back-to-back sees the new value.
    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (wb_en && wb_addr == ra1) rd1 = wb_data;
        if (wb_en && wb_addr == ra2) rd2 = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (cap_en) begin
                q1 <= rd1;
                q2 <= rd2;
            end
            if (wb_en)       rf[wb_addr]  <= wb_data;
            else if (ext_en) rf[ext_addr] <= ext_data;
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Issue stage for the 4-bit ALU: accept, operand read, capture, write-back.
// Optional ALU_SEQ_ZF_EN adds a captured zero flag output res_zf.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2+3*ADDR_W-1:0]         in_instr,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [1:0]                    alu_op,
    input  logic [DATA_W-1:0]             alu_r,
    input  logic                          alu_cf,
    output logic                          res_valid,
    output logic [DATA_W-1:0]             res_data,
    output logic                          res_cf,
`ifdef ALU_SEQ_ZF_EN
    output logic                          res_zf,
`endif
    output logic [ADDR_W-1:0]             res_rd,
    input  logic [ADDR_W-1:0]             dbg_addr,
    output logic [DATA_W-1:0]             dbg_data
);

    localparam int OP_LO  = op_lsb(ADDR_W);
    localparam int RD_LO  = rd_lsb(ADDR_W);
    localparam int RS1_LO = rs1_lsb(ADDR_W);
    localparam int RS2_LO = rs2_lsb(ADDR_W);

    state_t state;
    state_t state_nx;

    logic              accept;
    logic              ext_en;
    logic [1:0]        f_op;
    logic [ADDR_W-1:0] f_rd;
    logic [ADDR_W-1:0] f_rs1;
    logic [ADDR_W-1:0] f_rs2;
    logic [ADDR_W-1:0] rd_q;

    assign f_op  = in_instr[OP_LO +: OP_W];
    assign f_rd  = in_instr[RD_LO +: ADDR_W];
    assign f_rs1 = in_instr[RS1_LO +: ADDR_W];
    assign f_rs2 = in_instr[RS2_LO +: ADDR_W];

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid;
    assign ext_en   = wr_en && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op    <= '0;
            rd_q      <= '0;
            res_data  <= '0;
            res_cf    <= 1'b0;
            res_rd    <= '0;
            res_valid <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= f_op;
                rd_q   <= f_rd;
            end
            if (state == EXEC) begin
                res_data <= alu_r;
                res_cf   <= alu_cf;
                res_rd   <= rd_q;
            end
            res_valid <= (state == WB);
        end
    end

`ifdef ALU_SEQ_ZF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               res_zf <= 1'b0;
        else if (state == EXEC)  res_zf <= (alu_r == '0);
    end
`endif

    // Write-back occupies the strobe cycle; a same-cycle external write
    // loses the single write port.
    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (accept),
        .ra1      (f_rs1),
        .ra2      (f_rs2),
        .q1       (alu_a),
        .q2       (alu_b),
        .ext_en   (ext_en),
        .ext_addr (wr_addr),
        .ext_data (wr_data),
        .wb_en    (res_valid),
        .wb_addr  (res_rd),
        .wb_data  (res_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
